// File: rtl/gato_vga_pkg.sv
// Shared VGA 640x480@60 timing and gato board geometry for the sync generator and renderer.
package gato_vga_pkg;

  localparam int COORD_W = 11;

  localparam int H_DISP  = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;

  localparam int V_DISP  = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  // 3x3 board centred horizontally in the visible area.
  localparam int BOARD_CELL   = 160;
  localparam int BOARD_X0     = (H_DISP - 3 * BOARD_CELL) / 2;
  localparam int BOARD_Y0     = 0;
  localparam int BOARD_LINE_W = 4;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_window(input coord_t v, input int lo, input int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Clock divider: one-clk pixel_tick strobe every CLK_DIV system clocks.
module vga_pixel_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_tick;

  // Tick is the registered image of the terminal count, so with CLK_DIV=1 it sits at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      r_tick <= (r_div == DIV_LAST);
    end
  end

  assign pixel_tick = r_tick;

endmodule

// File: rtl/vga_sync_gato.sv
// VGA sync/coordinate generator for the gato renderer.
// Optional macro VGA_SYNC_DELAY_EN adds one pixel of delay on hsync/vsync.
module vga_sync_gato #(
  parameter int CLK_DIV = 4,
  parameter int H_DISP  = gato_vga_pkg::H_DISP,
  parameter int H_FP    = gato_vga_pkg::H_FP,
  parameter int H_SYNC  = gato_vga_pkg::H_SYNC,
  parameter int H_BP    = gato_vga_pkg::H_BP,
  parameter int V_DISP  = gato_vga_pkg::V_DISP,
  parameter int V_FP    = gato_vga_pkg::V_FP,
  parameter int V_SYNC  = gato_vga_pkg::V_SYNC,
  parameter int V_BP    = gato_vga_pkg::V_BP
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 video_mostrar,
  output gato_vga_pkg::coord_t pixel_x,
  output gato_vga_pkg::coord_t pixel_y,
  output logic                 pixel_tick,
  output logic                 frame_start
);

  localparam int CW      = gato_vga_pkg::COORD_W;
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] X_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_TOTAL - 1);

  logic          w_tick;
  logic          w_x_wrap;
  logic          w_y_wrap;
  logic [CW-1:0] w_x_next;
  logic [CW-1:0] w_y_next;

  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_video;
  logic          r_frame_start;

  vga_pixel_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_tick (
    .clk       (clk),
    .reset     (reset),
    .pixel_tick(w_tick)
  );

  assign w_x_wrap = (r_x == X_LAST);
  assign w_y_wrap = (r_y == Y_LAST);

  always_comb begin
    w_x_next = r_x;
    w_y_next = r_y;
    if (w_tick) begin
      w_x_next = w_x_wrap ? '0 : r_x + 1'b1;
      if (w_x_wrap) begin
        w_y_next = w_y_wrap ? '0 : r_y + 1'b1;
      end
    end
  end

  // Decode from next-state counters so the flags line up with pixel_x/pixel_y.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x           <= '0;
      r_y           <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_video       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_x           <= w_x_next;
      r_y           <= w_y_next;
      r_hsync       <= !gato_vga_pkg::in_window(w_x_next, H_DISP + H_FP, H_SYNC);
      r_vsync       <= !gato_vga_pkg::in_window(w_y_next, V_DISP + V_FP, V_SYNC);
      r_video       <= (int'(w_x_next) < H_DISP) && (int'(w_y_next) < V_DISP);
      r_frame_start <= w_tick && w_x_wrap && w_y_wrap;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic r_hsync_d;
  logic r_vsync_d;

  // Lag sync by one pixel to match a renderer that registers its colour output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync_d <= 1'b1;
      r_vsync_d <= 1'b1;
    end else if (w_tick) begin
      r_hsync_d <= r_hsync;
      r_vsync_d <= r_vsync;
    end
  end

  assign hsync = r_hsync_d;
  assign vsync = r_vsync_d;
`else
  assign hsync = r_hsync;
  assign vsync = r_vsync;
`endif

  assign video_mostrar = r_video;
  assign pixel_x       = r_x;
  assign pixel_y       = r_y;
  assign pixel_tick    = w_tick;
  assign frame_start   = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gato.sv
// Self-checking bench for vga_sync_gato: full-size timing plus two reduced-timing instances.
module tb_vga_sync_gato;

  typedef struct {
    int div, hd, hf, hs, hb, vd, vf, vs, vb;
  } cfg_t;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic        vid;
    logic        tick;
    logic        fs;
  } obs_t;

  typedef struct {
    int          n;
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        hs_d;
    logic        vid;
    logic        tick;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        d_hs, d_vs, d_vid, d_tick, d_fs;
  logic [10:0] d_x, d_y;
  logic        s_hs, s_vs, s_vid, s_tick, s_fs;
  logic [10:0] s_x, s_y;
  logic        o_hs, o_vs, o_vid, o_tick, o_fs;
  logic [10:0] o_x, o_y;

  vga_sync_gato dut_def (
    .clk(clk), .reset(reset), .hsync(d_hs), .vsync(d_vs), .video_mostrar(d_vid),
    .pixel_x(d_x), .pixel_y(d_y), .pixel_tick(d_tick), .frame_start(d_fs)
  );

  vga_sync_gato #(
    .CLK_DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_small (
    .clk(clk), .reset(reset), .hsync(s_hs), .vsync(s_vs), .video_mostrar(s_vid),
    .pixel_x(s_x), .pixel_y(s_y), .pixel_tick(s_tick), .frame_start(s_fs)
  );

  vga_sync_gato #(
    .CLK_DIV(1), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_one (
    .clk(clk), .reset(reset), .hsync(o_hs), .vsync(o_vs), .video_mostrar(o_vid),
    .pixel_x(o_x), .pixel_y(o_y), .pixel_tick(o_tick), .frame_start(o_fs)
  );

  int errors = 0;
  int checks = 0;
  int n = 0;           // clk edges since the last edge that sampled reset=1
  int hs_low_cnt = 0;
  logic count_en = 1'b0;

  cfg_t c_def, c_small, c_one;

  // Reference: position = number of pixel advances since reset, folded onto the frame.
  function automatic obs_t model(input cfg_t c, input int edges);
    obs_t o;
    int ht, vt, a, p, pp, xp, yp;
    ht = c.hd + c.hf + c.hs + c.hb;
    vt = c.vd + c.vf + c.vs + c.vb;
    a  = (edges >= 1) ? (edges - 1) / c.div : 0;
    p  = a % (ht * vt);
    o.x    = 11'(p % ht);
    o.y    = 11'(p / ht);
    o.vid  = ((p % ht) < c.hd) && ((p / ht) < c.vd);
    o.tick = (edges > 0) && (edges % c.div == 0);
    o.fs   = (edges >= 2) && ((edges - 1) % c.div == 0) && (p == 0);
`ifdef VGA_SYNC_DELAY_EN
    pp = (a == 0) ? -1 : (a - 1) % (ht * vt);
`else
    pp = p;
`endif
    if (pp < 0) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
    end else begin
      xp = pp % ht;
      yp = pp / ht;
      o.hs = !((xp >= c.hd + c.hf) && (xp < c.hd + c.hf + c.hs));
      o.vs = !((yp >= c.vd + c.vf) && (yp < c.vd + c.vf + c.vs));
    end
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s n=%0d got x=%0d y=%0d hs=%b vs=%b vid=%b tick=%b fs=%b required x=%0d y=%0d hs=%b vs=%b vid=%b tick=%b fs=%b",
                 name, n, act.x, act.y, act.hs, act.vs, act.vid, act.tick, act.fs,
                 exp.x, exp.y, exp.hs, exp.vs, exp.vid, exp.tick, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic obs_t obs_def();
    return {d_x, d_y, d_hs, d_vs, d_vid, d_tick, d_fs};
  endfunction
  function automatic obs_t obs_small();
    return {s_x, s_y, s_hs, s_vs, s_vid, s_tick, s_fs};
  endfunction
  function automatic obs_t obs_one();
    return {o_x, o_y, o_hs, o_vs, o_vid, o_tick, o_fs};
  endfunction

  // One clk edge, then compare all three instances against the model.
  task automatic step();
    @(posedge clk);
    if (reset) n = 0;
    else n++;
    #1;
    if (count_en && !d_hs) hs_low_cnt++;
    check("model_def", obs_def(), model(c_def, n));
    check("model_small", obs_small(), model(c_small, n));
    check("model_one", obs_one(), model(c_one, n));
  endtask

  vec_t tab[14];
  obs_t rst_exp;
  obs_t act;
  int k;
  int fs_cnt;

  initial begin
    c_def   = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
    c_small = '{2, 8, 2, 3, 2, 4, 1, 2, 1};
    c_one   = '{1, 8, 2, 3, 2, 4, 1, 2, 1};
    rst_exp = {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    //           n     x    y  hs hs_d vid tick
    tab[0]  = '{0,    0,   0, 1, 1, 1, 0};
    tab[1]  = '{4,    0,   0, 1, 1, 1, 1};
    tab[2]  = '{5,    1,   0, 1, 1, 1, 0};
    tab[3]  = '{2557, 639, 0, 1, 1, 1, 0};
    tab[4]  = '{2561, 640, 0, 1, 1, 0, 0};
    tab[5]  = '{2621, 655, 0, 1, 1, 0, 0};
    tab[6]  = '{2625, 656, 0, 0, 1, 0, 0};
    tab[7]  = '{2629, 657, 0, 0, 0, 0, 0};
    tab[8]  = '{3005, 751, 0, 0, 0, 0, 0};
    tab[9]  = '{3009, 752, 0, 1, 0, 0, 0};
    tab[10] = '{3013, 753, 0, 1, 1, 0, 0};
    tab[11] = '{3197, 799, 0, 1, 1, 0, 0};
    tab[12] = '{3200, 799, 0, 1, 1, 0, 1};
    tab[13] = '{3201, 0,   1, 1, 1, 1, 0};

    // Reset for 3 clks, then find the first tick.
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    act = obs_def();
    check("reset_state", act, rst_exp);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (d_tick) begin
        k = i;
        break;
      end
    end
    check_int("first_tick_clks", k, 4);

    // Table-driven walk through the first line of the full-size timing.
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      obs_t e;
      while (n < tab[i].n) step();
`ifdef VGA_SYNC_DELAY_EN
      e = {tab[i].x, tab[i].y, tab[i].hs_d, 1'b1, tab[i].vid, tab[i].tick, 1'b0};
`else
      e = {tab[i].x, tab[i].y, tab[i].hs, 1'b1, tab[i].vid, tab[i].tick, 1'b0};
`endif
      check($sformatf("vec%0d", i), obs_def(), e);
    end
    count_en = 1'b0;
    check_int("hsync_low_clks_per_line", hs_low_cnt, 96 * 4);

    // Mid-line reset at x=300 restores reset state on the next clk.
    reset = 1'b1;
    step();
    reset = 1'b0;
    while (n < 1201) step();
    check_int("at_x300", int'(d_x), 300);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midline_reset", obs_def(), rst_exp);

    // Reduced timing: three frame_start pulses across 730 clks (frames end at n=241,481,721).
    fs_cnt = 0;
    for (int i = 0; i < 730; i++) begin
      step();
      if (s_fs) fs_cnt++;
    end
    check_int("small_frame_starts", fs_cnt, 3);

    // CLK_DIV=1 holds the tick high once out of reset.
    check_int("div1_tick_held", int'(o_tick), 1);

    // Randomized run lengths and reset pulses, checked every clk against the model.
    for (int r = 0; r < 30; r++) begin
      int run_len, rst_len;
      run_len = $urandom_range(1, 500);
      rst_len = $urandom_range(1, 3);
      reset = 1'b0;
      repeat (run_len) step();
      reset = 1'b1;
      repeat (rst_len) step();
      check("rand_reset", obs_small(), rst_exp);
    end
    reset = 1'b0;
    repeat (50) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
